// File: rtl/bus_pkg.sv
// Shared bus constants, slave FSM state encoding and burst-length helper.
// Latency: n/a. Backpressure: n/a.
package bus_pkg;

    localparam int BUS_DATA_W  = 32;
    localparam int BUS_BURST_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_LAT,
        S_READ_BURST,
        S_READ_END,
        S_WRITE,
        S_ERROR
    } bus_state_e;

    // burstSize is encoded as length-1; widen so 255 -> 256 fits.
    function automatic logic [BUS_BURST_W:0] burst_len(input logic [BUS_BURST_W-1:0] burst_size);
        return {1'b0, burst_size} + 9'd1;
    endfunction

endpackage

// File: rtl/bus_burst_ram_slave_if.sv
// Shared address/data bus as seen by one slave; master and slave views.
// Latency: n/a (wires only). Backpressure: none, bus has no wait states.
interface bus_burst_ram_slave_if;
    import bus_pkg::*;

    logic [BUS_DATA_W-1:0]  addressDataIn;
    logic [BUS_BURST_W-1:0] burstSizeIn;
    logic                   beginTransactionIn;
    logic                   endTransactionIn;
    logic                   dataValidIn;
    logic                   readNotWriteIn;
    logic                   busErrorIn;
    logic [BUS_DATA_W-1:0]  addressDataOut;
    logic                   endTransactionOut;
    logic                   dataValidOut;
    logic                   busErrorOut;
    logic                   busy;

    modport slave (
        input  addressDataIn, burstSizeIn, beginTransactionIn, endTransactionIn,
               dataValidIn, readNotWriteIn, busErrorIn,
        output addressDataOut, endTransactionOut, dataValidOut, busErrorOut, busy
    );

    modport master (
        output addressDataIn, burstSizeIn, beginTransactionIn, endTransactionIn,
               dataValidIn, readNotWriteIn, busErrorIn,
        input  addressDataOut, endTransactionOut, dataValidOut, busErrorOut, busy
    );

endinterface

// File: rtl/bus_ram_sp_sync.sv
// Single-port synchronous RAM, shaped for block-RAM inference.
// Latency: 1 cycle read (registered), synchronous write. Backpressure: none.
module bus_ram_sp_sync #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_burst_ram_slave.sv
// SSRAM bus slave: single/burst reads and writes to a fixed window; BUS_RAM_SLAVE_ERR_CHECK_EN adds misalign/wrap errors.
// Latency: first read beat 2 cycles after begin, then back-to-back; writes land the cycle they are valid.
// Backpressure: none; reads stream without wait states, write beats beyond the burst length are dropped.
module bus_burst_ram_slave
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_WIDTH   = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    bus_burst_ram_slave_if.slave  bus
);

    bus_state_e             state_q, state_n;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_n;
    logic [BUS_BURST_W:0]   cnt_q, cnt_n;
    logic                   dv_q, dv_n;
    logic                   end_q, end_n;
    logic                   busy_q;
    logic                   ptr_inc;
    logic                   hit;
    logic                   ram_we, ram_re;
    logic [BUS_DATA_W-1:0]  ram_rdata;
`ifdef BUS_RAM_SLAVE_ERR_CHECK_EN
    logic                   err_q, err_n;
    logic                   wrap_q, wrap_n;
`endif

    assign hit = bus.beginTransactionIn &&
                 (bus.addressDataIn[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        dv_n    = 1'b0;
        end_n   = 1'b0;
        ptr_inc = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
`ifdef BUS_RAM_SLAVE_ERR_CHECK_EN
        err_n   = 1'b0;
        wrap_n  = wrap_q;
`endif
        if (bus.busErrorIn) begin
            state_n = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        ptr_n = bus.addressDataIn[ADDR_WIDTH+1:2];
`ifdef BUS_RAM_SLAVE_ERR_CHECK_EN
                        wrap_n = 1'b0;
                        if (bus.addressDataIn[1:0] != 2'b00) begin
                            state_n = S_ERROR;
                            err_n   = 1'b1;
                            end_n   = 1'b1;
                        end else
`endif
                        if (bus.readNotWriteIn) begin
                            state_n = S_READ_LAT;
                            cnt_n   = {1'b0, bus.burstSizeIn};
                        end else begin
                            state_n = S_WRITE;
                            cnt_n   = burst_len(bus.burstSizeIn);
                        end
                    end
                end
                S_READ_LAT: begin
                    ram_re  = 1'b1;
                    ptr_inc = 1'b1;
                    dv_n    = 1'b1;
                    state_n = S_READ_BURST;
                end
                // cnt_q counts reads still to issue; the word on the bus now was issued last cycle.
                S_READ_BURST: begin
                    if (cnt_q == '0) begin
                        state_n = S_READ_END;
                        end_n   = 1'b1;
                    end else
`ifdef BUS_RAM_SLAVE_ERR_CHECK_EN
                    if (wrap_q) begin
                        state_n = S_ERROR;
                        err_n   = 1'b1;
                        end_n   = 1'b1;
                    end else
`endif
                    begin
                        ram_re  = 1'b1;
                        ptr_inc = 1'b1;
                        cnt_n   = cnt_q - 1'b1;
                        dv_n    = 1'b1;
                    end
                end
                S_READ_END: state_n = S_IDLE;
                // cnt_q counts beats still accepted; a beat with the end strobe is still written.
                S_WRITE: begin
                    if (bus.endTransactionIn) begin
                        state_n = S_IDLE;
                    end
                    if (bus.dataValidIn && (cnt_q != '0)) begin
`ifdef BUS_RAM_SLAVE_ERR_CHECK_EN
                        if (wrap_q) begin
                            state_n = S_ERROR;
                            err_n   = 1'b1;
                            end_n   = 1'b1;
                        end else
`endif
                        begin
                            ram_we  = 1'b1;
                            ptr_inc = 1'b1;
                            cnt_n   = cnt_q - 1'b1;
                        end
                    end
                end
                S_ERROR: state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
        if (ptr_inc) begin
            ptr_n = ptr_q + 1'b1;
`ifdef BUS_RAM_SLAVE_ERR_CHECK_EN
            wrap_n = wrap_q | (&ptr_q);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dv_q    <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BUS_RAM_SLAVE_ERR_CHECK_EN
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
            dv_q    <= dv_n;
            end_q   <= end_n;
            busy_q  <= (state_n != S_IDLE);
`ifdef BUS_RAM_SLAVE_ERR_CHECK_EN
            err_q   <= err_n;
            wrap_q  <= wrap_n;
`endif
        end
    end

    // Writes are blocked during reset so an interrupted beat never lands.
    bus_ram_sp_sync #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (BUS_DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we & ~reset),
        .re    (ram_re),
        .addr  (ptr_q),
        .wdata (bus.addressDataIn),
        .rdata (ram_rdata)
    );

    assign bus.addressDataOut    = dv_q ? ram_rdata : '0;
    assign bus.dataValidOut      = dv_q;
    assign bus.endTransactionOut = end_q;
    assign bus.busy              = busy_q;
`ifdef BUS_RAM_SLAVE_ERR_CHECK_EN
    assign bus.busErrorOut       = err_q;
`else
    assign bus.busErrorOut       = 1'b0;
`endif

endmodule

// File: doc/bus_burst_ram_slave.md
Name: bus_burst_ram_slave

Overview:
- On-chip SSRAM bus slave. Serves single and burst read/write transactions issued by bus masters, including the DMA custom-instruction block, on the shared address/data bus.
- Sits directly downstream of the DMA bus master, behind the arbiter. It is the target that the DMA reads from and writes to.
- Decodes a fixed address window, streams read data with 1-cycle RAM latency and terminates read bursts. Write bursts are terminated by the master.

Parameters:
- BASE_ADDRESS, 32'h5000_0000, byte base address of the window; must be aligned to the window size.
- ADDR_WIDTH, 9, word-address width; window = 2^ADDR_WIDTH 32-bit words (default 512 words = 2 KiB).

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- addressDataIn  in  32  address during begin cycle; write data while dataValidIn=1
- burstSizeIn  in  8  burst length minus 1 (0 = single word, 255 = 256 words)
- beginTransactionIn  in  1  one-cycle transaction start strobe
- endTransactionIn  in  1  master-driven end of write transaction
- dataValidIn  in  1  write data valid
- readNotWriteIn  in  1  1 = read, 0 = write; sampled at begin
- busErrorIn  in  1  abort from another agent; return to IDLE
- addressDataOut  out  32  read data; 0 when not driving
- endTransactionOut  out  1  one-cycle pulse closing a read burst or error
- dataValidOut  out  1  read data valid
- busErrorOut  out  1  one-cycle error pulse
- busy  out  1  1 while not IDLE (debug/status)

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset mid-transaction returns to IDLE next cycle with no further pulses; RAM contents are not cleared.
- Hit decode:
  - Applies only when beginTransactionIn=1.
  - Hit when addressDataIn[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2].
  - A miss is ignored entirely; the slave stays IDLE and drives nothing.
- Sampled at begin: word pointer = addressDataIn[ADDR_WIDTH+1:2]; remaining count = burstSizeIn (9-bit, holds 0..255); direction.
- FSM states: IDLE, READ_LAT, READ_BURST, READ_END, WRITE, ERROR.
- IDLE:
  - Hit read → READ_LAT.
  - Hit write → WRITE.
  - beginTransactionIn while not IDLE is ignored.
- READ_LAT: one cycle of RAM address setup → READ_BURST.
- READ_BURST:
  - Each cycle: dataValidOut=1 and addressDataOut=RAM[pointer]; pointer+1; count-1.
  - After the word with count==0 → READ_END.
  - First dataValidOut appears exactly 2 cycles after the begin cycle.
  - Words are back-to-back; there are no wait states.
- READ_END: endTransactionOut=1 for one cycle → IDLE.
- WRITE:
  - Each cycle with dataValidIn=1: RAM[pointer] <= addressDataIn; pointer+1.
  - Beats beyond burstSizeIn+1 are dropped.
  - endTransactionIn=1 → IDLE; a valid beat in the same cycle is still written.
- busErrorIn=1 in any state → IDLE next cycle. No endTransactionOut, no busErrorOut.
- Pointer arithmetic is ADDR_WIDTH bits. Wrap-around behaviour is defined under Optional Feature.
- addressDataOut is forced to 0 whenever dataValidOut=0, so the bus can be wire-ORed.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: BUS_RAM_SLAVE_ERR_CHECK_EN.
- Defined:
  - Hit with addressDataIn[1:0] != 0 → ERROR state: busErrorOut=1 and endTransactionOut=1 in the same cycle → IDLE. No RAM access.
  - Burst whose pointer would pass the last window word: the error check runs before the access. The beat that would wrap is not read/written; instead the slave goes to ERROR.
- Undefined: ERROR is unreachable, busErrorOut is tied 0, address bits [1:0] are ignored, and the pointer wraps modulo 2^ADDR_WIDTH.

Decomposition:
- Shared package bus_pkg:
  - FSM state localparams.
  - Bus width constants: data 32, burst 8.
  - Burst-length helper constant: length = burstSize + 1.
- One sub-module: bus_ram_sp_sync, a single-port synchronous 32-bit RAM of 2^ADDR_WIDTH words. Read data is registered with 1-cycle latency; write is synchronous. It is kept separate so the implementation can map it to block RAM.

Test Plan:
- Single read: preload RAM[3]=32'hDEADBEEF; begin read at 0x5000000C, burst 0 → dataValidOut at begin+2 with 0xDEADBEEF, then endTransactionOut at begin+3, busy=0 at begin+4.
- Burst write then read:
  - Write to 0x50000100, burst 7, data 1..8 with a 2-cycle gap after beat 4, then endTransactionIn.
  - Read back with burst 7 → 8 consecutive valid beats 1..8, then one end pulse.
- Miss: begin at 0x40000000 → no outputs toggle for 10 cycles; busy stays 0.
- Abort: busErrorIn during the 3rd read beat of burst 15 → IDLE next cycle, no end/error pulse; a following single read succeeds.
- Reset mid-burst: reset during write beat 2 of 4 → all outputs 0 next cycle; beats 0-1 remain written, beats 2-3 are not.
- Boundary: read at 0x500007FC with burst 1:
  - With BUS_RAM_SLAVE_ERR_CHECK_EN: one valid beat, then busErrorOut and endTransactionOut together.
  - Without it: beats return RAM[511] then RAM[0]; misaligned 0x50000002 reads RAM[0].
